// File: rtl/reg_file_pkg.sv
// Shared helpers for the parametrised register file.
// Address-width derivation and reset-value generation.
package reg_file_pkg;

  function automatic int rf_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [63:0] rf_init(
    input int idx,
    input int width
  );
    logic [63:0] v;
    v = 64'(idx);
    if (width < 64) v = v & ((64'd1 << width) - 64'd1);
    return v;
  endfunction

endpackage

// File: rtl/reg_file_param_rf_scoreboard.sv
// Per-register busy scoreboard for pending producers.
// Set (reservation) beats clear (write-back) on the same register.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_addr_a,
  input  logic [ADDR_W-1:0] q_addr_b,
  output logic              busy_nxt_a,
  output logic              busy_nxt_b
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clear first so a same-cycle set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  // Lookup of the post-update state for both read ports.
  always_comb begin
    busy_nxt_a = 1'b0;
    busy_nxt_b = 1'b0;
    if (32'(q_addr_a) < DEPTH) busy_nxt_a = busy_d[q_addr_a];
    if (32'(q_addr_b) < DEPTH) busy_nxt_b = busy_d[q_addr_b];
  end

  // Busy register; reset drops any pending set or clear.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_file_param.sv
// Register file: 2 registered read ports, 1 write port,
// write-to-read bypass, optional zero register, busy flags.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  localparam int ADDR_W  = rf_addr_w(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_busy_a_q, rd_busy_a_d;
  logic             rd_busy_b_q, rd_busy_b_d;

  logic wr_ok, rsv_ok, ok_a, ok_b;
  logic bsy_a, bsy_b;

  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] a
  );
    return (32'(a) < DEPTH) &&
           !(ZERO_REG && (a == '0));
  endfunction

  // Qualify every address against range and zero register.
  always_comb begin
    wr_ok  = wr_en  && addr_ok(wr_addr);
    rsv_ok = rsv_en && addr_ok(rsv_addr);
    ok_a   = addr_ok(rd_addr_a);
    ok_b   = addr_ok(rd_addr_b);
  end

  // Post-write storage image.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (rsv_ok),
    .set_addr   (rsv_addr),
    .clr_en     (wr_ok),
    .clr_addr   (wr_addr),
    .q_addr_a   (rd_addr_a),
    .q_addr_b   (rd_addr_b),
    .busy_nxt_a (bsy_a),
    .busy_nxt_b (bsy_b)
  );

  // Read capture; BYPASS picks post- or pre-write data.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_busy_a_d = rd_busy_a_q;
    rd_busy_b_d = rd_busy_b_q;
    if (rd_en) begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
      rd_busy_a_d = 1'b0;
      rd_busy_b_d = 1'b0;
      if (ok_a) begin
        rd_data_a_d = BYPASS ? mem_d[rd_addr_a]
                             : mem_q[rd_addr_a];
        rd_busy_a_d = bsy_a;
      end
      if (ok_b) begin
        rd_data_b_d = BYPASS ? mem_d[rd_addr_b]
                             : mem_q[rd_addr_b];
        rd_busy_b_d = bsy_b;
      end
    end
  end

  // State update; reset is a one-edge parallel load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= WIDTH'(rf_init(i, WIDTH));
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_busy_a_q <= 1'b0;
      rd_busy_b_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_busy_a_q <= rd_busy_a_d;
      rd_busy_b_q <= rd_busy_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_busy_a = rd_busy_a_q;
  assign rd_busy_b = rd_busy_b_q;

endmodule
